// File: rtl/stk_pkg.sv
// rtl/stk_pkg.sv - shared descriptor-pool types and constants for the stk pipeline
package stk_pkg;
    localparam int BANKS_N        = 4;
    localparam int C_BANK_LINES_N = 64;
    localparam int DESC_N         = BANKS_N * C_BANK_LINES_N;
    localparam int PTR_W          = $clog2(DESC_N);
    localparam int DL_FIFO_N      = 4;

    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/stk_pipe_dl_if.sv
// rtl/stk_pipe_dl_if.sv - free-in / dealloc-out handshake bundle of the return engine
interface stk_pipe_dl_if;
    import stk_pkg::*;

    logic i_free_vld;
    ptr_t i_free_ptr;
    logic o_free_rdy_r;
    logic o_dealloc_vld_r;
    ptr_t o_dealloc_ptr_r;

    modport slave (
        input  i_free_vld, i_free_ptr,
        output o_free_rdy_r, o_dealloc_vld_r, o_dealloc_ptr_r
    );

    modport master (
        output i_free_vld, i_free_ptr,
        input  o_free_rdy_r, o_dealloc_vld_r, o_dealloc_ptr_r
    );
endinterface

// File: rtl/stk_pipe_dl_fifo.sv
// rtl/stk_pipe_dl_fifo.sv - flop-based return buffer with registered full/empty
module stk_pipe_dl_fifo
    import stk_pkg::*;
#(
    parameter  int FIFO_N = DL_FIFO_N,
    localparam int OCC_W  = $clog2(FIFO_N + 1),
    localparam int AW     = $clog2(FIFO_N)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  ptr_t             push_ptr,
    input  logic             pop,
    output ptr_t             head,
    output logic [OCC_W-1:0] occupancy,
    output logic             full_r,
    output logic             empty_r
);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_N);

    ptr_t             mem [FIFO_N];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [OCC_W-1:0] occ_next;

    always_comb begin
        occ_next = occupancy;
        case ({push, pop})
            2'b10:   occ_next = occupancy + 1'b1;
            2'b01:   occ_next = occupancy - 1'b1;
            default: occ_next = occupancy;
        endcase
    end

    assign head = mem[rd_idx];

    // Indices wrap naturally because FIFO_N is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            occupancy <= '0;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            occupancy <= occ_next;
            full_r    <= (occ_next == FULL_OCC);
            empty_r   <= (occ_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_ptr;
    end
endmodule

// File: rtl/stk_pipe_dl.sv
// rtl/stk_pipe_dl.sv - descriptor-return engine: buffers freed pointers and drains them to the allocator
module stk_pipe_dl
    import stk_pkg::*;
#(
    parameter  int FIFO_N = DL_FIFO_N,
    parameter  int DESC_N = stk_pkg::DESC_N,
    localparam int CNT_W  = $clog2(DESC_N + 1),
    localparam int OCC_W  = $clog2(FIFO_N + 1)
) (
    input  logic             clk,
    input  logic             arst_n,
    stk_pipe_dl_if.slave     dl,
    input  logic             i_ad_alloc,
    input  logic             i_al_busy_r,
    output logic [CNT_W-1:0] o_live_cnt_r,
    output logic             o_idle_r,
    output logic [1:0]       o_err_r
);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_N);
    localparam logic [CNT_W-1:0] LIVE_MAX = CNT_W'(DESC_N);

    logic             push;
    logic             pop;
    ptr_t             head;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] live_next;
    logic [1:0]       err_set;

    assign push = dl.i_free_vld & dl.o_free_rdy_r;
    assign pop  = ~fifo_empty & ~i_al_busy_r;

    stk_pipe_dl_fifo #(.FIFO_N(FIFO_N)) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push),
        .push_ptr  (dl.i_free_ptr),
        .pop       (pop),
        .head      (head),
        .occupancy (occ),
        .full_r    (fifo_full),
        .empty_r   (fifo_empty)
    );

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    // The decrement comes from our own registered return pulse, so it lags the pop by a cycle.
    always_comb begin
        live_next = o_live_cnt_r;
        err_set   = 2'b00;
        case ({i_ad_alloc, dl.o_dealloc_vld_r})
            2'b10: begin
                if (o_live_cnt_r == LIVE_MAX) err_set[1] = 1'b1;
                else                          live_next  = o_live_cnt_r + 1'b1;
            end
            2'b01: begin
                if (o_live_cnt_r == '0) err_set[0] = 1'b1;
                else                    live_next  = o_live_cnt_r - 1'b1;
            end
            default: live_next = o_live_cnt_r;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dl.o_free_rdy_r    <= 1'b1;
            dl.o_dealloc_vld_r <= 1'b0;
            dl.o_dealloc_ptr_r <= '0;
            o_live_cnt_r       <= '0;
            o_idle_r           <= 1'b1;
            o_err_r            <= 2'b00;
        end else begin
            dl.o_free_rdy_r    <= (occ_next < FULL_OCC);
            dl.o_dealloc_vld_r <= pop;
            if (pop) dl.o_dealloc_ptr_r <= head;
            o_live_cnt_r       <= live_next;
            o_idle_r           <= (live_next == '0) && (occ_next == '0) && !pop;
            o_err_r            <= o_err_r | err_set;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!arst_n)
        !(dl.i_free_vld && !dl.o_free_rdy_r));

    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_stk_pipe_dl.sv
// tb/tb_stk_pipe_dl.sv - self-checking bench for stk_pipe_dl
module tb_stk_pipe_dl;
    import stk_pkg::*;

    localparam int CNT_W = $clog2(DESC_N + 1);

    logic             clk;
    logic             arst_n;
    logic             i_ad_alloc;
    logic             i_al_busy_r;
    logic [CNT_W-1:0] o_live_cnt_r;
    logic             o_idle_r;
    logic [1:0]       o_err_r;

    stk_pipe_dl_if dl ();

    stk_pipe_dl dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .dl           (dl),
        .i_ad_alloc   (i_ad_alloc),
        .i_al_busy_r  (i_al_busy_r),
        .o_live_cnt_r (o_live_cnt_r),
        .o_idle_r     (o_idle_r),
        .o_err_r      (o_err_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic fv;
        ptr_t ptr;
        logic busy;
        logic alloc;
        logic e_vld;
        logic e_rdy;
        int   e_live;
        logic e_idle;
        logic [1:0] e_err;
    } vec_t;

    vec_t tbl[$];
    ptr_t sb[$];
    int   applied;
    int   miscompares;
    int   ret_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic fv, input ptr_t ptr, input logic busy, input logic alloc,
                                input logic e_vld, input logic e_rdy, input int e_live,
                                input logic e_idle, input logic [1:0] e_err);
        vec_t v;
        v.fv = fv; v.ptr = ptr; v.busy = busy; v.alloc = alloc;
        v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_live = e_live; v.e_idle = e_idle; v.e_err = e_err;
        return v;
    endfunction

    // Drives one cycle of inputs, records accepted pointers, returns #1 after the edge.
    task automatic cyc(input logic fv, input ptr_t ptr, input logic busy, input logic alloc);
        @(negedge clk);
        dl.i_free_vld = fv;
        dl.i_free_ptr = ptr;
        i_al_busy_r   = busy;
        i_ad_alloc    = alloc;
        if (fv && dl.o_free_rdy_r) sb.push_back(ptr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  32'(dl.o_free_rdy_r),    32'd1);
        check({tag, "_vld"},  32'(dl.o_dealloc_vld_r), 32'd0);
        check({tag, "_ptr"},  32'(dl.o_dealloc_ptr_r), 32'd0);
        check({tag, "_live"}, 32'(o_live_cnt_r),       32'd0);
        check({tag, "_idle"}, 32'(o_idle_r),           32'd1);
        check({tag, "_err"},  32'(o_err_r),            32'd0);
    endtask

    // Scoreboard: every return pulse must match the oldest accepted pointer.
    always @(posedge clk) begin
        #1;
        if (arst_n && dl.o_dealloc_vld_r) begin
            if (sb.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL sb_unexpected: got vld ptr 0x%0h expected no return", dl.o_dealloc_ptr_r);
            end else begin
                check("sb_order", 32'(dl.o_dealloc_ptr_r), 32'(sb.pop_front()));
                ret_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        applied = 0; miscompares = 0; ret_cnt = 0;
        arst_n = 1'b0;
        dl.i_free_vld = 1'b0; dl.i_free_ptr = '0;
        i_ad_alloc = 1'b0; i_al_busy_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // Minimum latency: accepted at edge N, return visible after edge N+1 only.
        cyc(0, '0, 0, 1);
        check("lat_live1", 32'(o_live_cnt_r), 32'd1);
        cyc(1, 8'h05, 0, 0);
        check("lat_vld_n", 32'(dl.o_dealloc_vld_r), 32'd0);
        cyc(0, '0, 0, 0);
        check("lat_vld_n1", 32'(dl.o_dealloc_vld_r), 32'd1);
        check("lat_ptr",    32'(dl.o_dealloc_ptr_r), 32'h05);
        cyc(0, '0, 0, 0);
        check("lat_vld_n2", 32'(dl.o_dealloc_vld_r), 32'd0);
        check("lat_live0",  32'(o_live_cnt_r),       32'd0);
        check("lat_idle",   32'(o_idle_r),           32'd1);

        // Sustained push every cycle with a matching alloc.
        base = ret_cnt;
        for (int i = 0; i < 32; i++) begin
            cyc(1, ptr_t'(8'h80 + i), 0, 1);
            check("b2b_rdy", 32'(dl.o_free_rdy_r), 32'd1);
            check("b2b_occ_le2", 32'(dut.u_fifo.occupancy <= 2), 32'd1);
        end
        repeat (3) cyc(0, '0, 0, 0);
        check("b2b_returns", 32'(ret_cnt - base), 32'd32);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_live", 32'(o_live_cnt_r), 32'd0);
        check("b2b_idle", 32'(o_idle_r), 32'd1);

        // Busy fill: allocs, 4 pushes while busy, then drain on busy drop.
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(0, '0, 1, 1, 0, 1, i, 0, 2'b00));
        tbl.push_back(mk(1, 8'h01, 1, 0, 0, 1, 4, 0, 2'b00));
        tbl.push_back(mk(1, 8'h12, 1, 0, 0, 1, 4, 0, 2'b00));
        tbl.push_back(mk(1, 8'h23, 1, 0, 0, 1, 4, 0, 2'b00));
        tbl.push_back(mk(1, 8'h34, 1, 0, 0, 0, 4, 0, 2'b00));
        tbl.push_back(mk(0, '0,    1, 0, 0, 0, 4, 0, 2'b00));
        tbl.push_back(mk(0, '0,    1, 0, 0, 0, 4, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 1, 1, 4, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 1, 1, 3, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 1, 1, 2, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 1, 1, 1, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 0, 1, 0, 1, 2'b00));
        // Live counting with an alloc coincident with a return.
        tbl.push_back(mk(0, '0,    0, 1, 0, 1, 1, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 1, 0, 1, 2, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 1, 0, 1, 3, 0, 2'b00));
        tbl.push_back(mk(1, 8'hA0, 0, 0, 0, 1, 3, 0, 2'b00));
        tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 1, 3, 0, 2'b00));
        tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 1, 2, 0, 2'b00));
        tbl.push_back(mk(1, 8'hA3, 0, 1, 1, 1, 2, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 1, 1, 1, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 0, 1, 0, 1, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 0, 1, 0, 1, 2'b00));
        // Return with nothing outstanding: underflow, count holds at 0.
        tbl.push_back(mk(1, 8'h55, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 1, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, '0,    0, 0, 0, 1, 0, 1, 2'b01));
        tbl.push_back(mk(0, '0,    0, 0, 0, 1, 0, 1, 2'b01));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].fv, tbl[i].ptr, tbl[i].busy, tbl[i].alloc);
            check($sformatf("v%0d_vld", i),  32'(dl.o_dealloc_vld_r), 32'(tbl[i].e_vld));
            check($sformatf("v%0d_rdy", i),  32'(dl.o_free_rdy_r),    32'(tbl[i].e_rdy));
            check($sformatf("v%0d_live", i), 32'(o_live_cnt_r),       32'(tbl[i].e_live));
            check($sformatf("v%0d_idle", i), 32'(o_idle_r),           32'(tbl[i].e_idle));
            check($sformatf("v%0d_err", i),  32'(o_err_r),            32'(tbl[i].e_err));
        end

        // Saturate the live counter, then one more alloc overflows.
        for (int i = 0; i < DESC_N; i++) cyc(0, '0, 0, 1);
        check("ovf_live_max", 32'(o_live_cnt_r), 32'(DESC_N));
        check("ovf_err_pre",  32'(o_err_r),      32'd1);
        cyc(0, '0, 0, 1);
        check("ovf_live_hold", 32'(o_live_cnt_r), 32'(DESC_N));
        check("ovf_err",       32'(o_err_r),      32'd3);
        repeat (2) cyc(0, '0, 0, 0);
        check("ovf_err_sticky", 32'(o_err_r), 32'd3);

        // Reset with three pointers queued behind a busy allocator.
        cyc(1, 8'h61, 1, 0);
        cyc(1, 8'h62, 1, 0);
        cyc(1, 8'h63, 1, 0);
        check("rst_pre_idle", 32'(o_idle_r), 32'd0);
        @(negedge clk);
        arst_n = 1'b0;
        dl.i_free_vld = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0, 0);
            check("rst_post_vld",  32'(dl.o_dealloc_vld_r), 32'd0);
            check("rst_post_idle", 32'(o_idle_r),           32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
